// File: rtl/wb_mem_bist.sv
// wb_mem_bist: Wishbone initiator that writes a seeded pattern over a word range, reads it back and checks it
// Ports: wb_clk_i clock, wb_rst_i async active-low reset; start + cfg_* launch a run (config sampled on start);
// sdr_init_done holds traffic until the controller is ready; busy/done/pass/timeout/err_count/first_err_addr
// report status; wb_* is the registered Wishbone master port (incrementing bursts, sel always 4'hF while stb).
module wb_mem_bist #(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int TO_CYC = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [APP_AW-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_num_words,
    input  logic [7:0]        cfg_burst_len,
    input  logic [31:0]       cfg_seed,
    input  logic              sdr_init_done,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [APP_AW-1:0] first_err_addr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [APP_DW-1:0] wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [APP_DW-1:0] wb_dat_i
);
    localparam int TW = $clog2(TO_CYC + 1);
    typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH} state_t;
    state_t state;
    logic [APP_AW-1:0] base_q;
    logic [15:0] num_q, idx, words_left, burst_l, idx_nxt;
    logic [7:0] bl_q, beats_left;
    logic [31:0] seed_q;
    logic [TW-1:0] tcnt;
    logic launch, last_beat, last_word, rd_err;

    function automatic logic [APP_DW-1:0] pat(input logic [31:0] s, input logic [15:0] i);
        return APP_DW'(s ^ {i, ~i});
    endfunction

    assign burst_l   = (words_left < {8'd0, bl_q}) ? words_left : {8'd0, bl_q};
    assign idx_nxt   = idx + 16'd1;
    assign last_beat = beats_left == 8'd1;
    assign last_word = words_left == 16'd1;
    assign rd_err    = !wb_we_o && (wb_dat_i != wb_dat_o);
    // A new burst starts from the init wait or from either one-cycle gap; the read gap starts read bursts.
    assign launch    = (state == WAIT_INIT && sdr_init_done) || state == WR_GAP || state == RD_GAP;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state          <= IDLE;
            base_q         <= '0;
            num_q          <= '0;
            idx            <= '0;
            words_left     <= '0;
            bl_q           <= '0;
            beats_left     <= '0;
            seed_q         <= '0;
            tcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_dat_o       <= '0;
            wb_sel_o       <= '0;
            wb_cti_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !done) begin
                        base_q         <= cfg_base_addr & ~APP_AW'(3);
                        num_q          <= cfg_num_words;
                        bl_q           <= (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
                        seed_q         <= cfg_seed;
                        idx            <= '0;
                        words_left     <= cfg_num_words;
                        wb_addr_o      <= cfg_base_addr & ~APP_AW'(3);
                        wb_dat_o       <= pat(cfg_seed, 16'd0);
                        err_count      <= '0;
                        timeout        <= 1'b0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= (cfg_num_words == 16'd0) ? FINISH : WAIT_INIT;
                    end
                end
                WR_BURST, RD_BURST: begin
                    if (wb_ack_i) begin
                        idx        <= idx_nxt;
                        words_left <= words_left - 16'd1;
                        beats_left <= beats_left - 8'd1;
                        wb_addr_o  <= wb_addr_o + APP_AW'(4);
                        wb_dat_o   <= pat(seed_q, idx_nxt);
                        tcnt       <= '0;
                        wb_cti_o   <= (beats_left == 8'd2) ? 3'b111 : 3'b010;
                        if (rd_err) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            if (err_count == 16'd0)
                                first_err_addr <= wb_addr_o;
                        end
                        if (last_beat) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= '0;
                            wb_cti_o <= '0;
                            state    <= last_word ? (wb_we_o ? RD_GAP : FINISH) : (wb_we_o ? WR_GAP : RD_GAP);
                        end
                        // End of the write pass rewinds to word 0 for the read pass.
                        if (last_word && wb_we_o) begin
                            idx        <= '0;
                            words_left <= num_q;
                            wb_addr_o  <= base_q;
                            wb_dat_o   <= pat(seed_q, 16'd0);
                        end
                    end else if (tcnt == TW'(TO_CYC - 1)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_cti_o <= '0;
                        timeout  <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 16'd0) && !timeout;
                    state <= IDLE;
                end
                default: ;
            endcase
            if (launch) begin
                wb_cyc_o   <= 1'b1;
                wb_stb_o   <= 1'b1;
                wb_we_o    <= state != RD_GAP;
                wb_sel_o   <= 4'hF;
                beats_left <= burst_l[7:0];
                wb_cti_o   <= (burst_l == 16'd1) ? 3'b111 : 3'b010;
                tcnt       <= '0;
                state      <= (state == RD_GAP) ? RD_BURST : WR_BURST;
            end
        end
    end
endmodule

// File: tb/tb_wb_mem_bist.sv
// tb_wb_mem_bist: self-checking bench for wb_mem_bist with a memory slave and a burst-level reference model
module tb_wb_mem_bist;
    localparam int AW = 26;
    localparam int TO_CYC = 1023;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sdr_init_done = 1'b1;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [15:0] cfg_num_words = '0;
    logic [7:0] cfg_burst_len = '0;
    logic [31:0] cfg_seed = '0;
    logic busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0;
    logic [AW-1:0] wb_addr_o;
    logic [31:0] wb_dat_o, wb_dat_i = '0;
    logic [3:0] wb_sel_o;
    logic [2:0] wb_cti_o;
    int checks = 0, fails = 0;

    wb_mem_bist #(.APP_AW(AW), .APP_DW(32), .TO_CYC(TO_CYC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_words(cfg_num_words), .cfg_burst_len(cfg_burst_len), .cfg_seed(cfg_seed),
        .sdr_init_done(sdr_init_done), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    // Zero-wait memory slave plus bus monitor, acting on the falling edge.
    logic [31:0] mem [int];
    int corrupt_addr = -1, stall_beat = -1, wr_acks = 0, gap_run = 0, stb_cycles = 0;
    bit prev_cyc = 1'b0;
    int gaps[$];
    logic log_we[$];
    int log_addr[$];
    logic [31:0] log_dat[$];
    logic [2:0] log_cti[$];
    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) stb_cycles++;
        if (!wb_cyc_o && prev_cyc) gap_run = 1;
        else if (!wb_cyc_o && gap_run > 0) gap_run++;
        if (wb_cyc_o && !prev_cyc && gap_run > 0) begin
            gaps.push_back(gap_run);
            gap_run = 0;
        end
        prev_cyc = wb_cyc_o;
        wb_ack_i = 1'b0;
        if (rst_n && wb_cyc_o && wb_stb_o && !(wb_we_o && wr_acks == stall_beat)) begin
            wb_ack_i = 1'b1;
            log_we.push_back(wb_we_o);
            log_addr.push_back(int'(wb_addr_o));
            log_dat.push_back(wb_dat_o);
            log_cti.push_back(wb_cti_o);
            if (wb_we_o) begin
                mem[int'(wb_addr_o)] = wb_dat_o;
                wr_acks++;
            end else begin
                wb_dat_i = mem.exists(int'(wb_addr_o)) ? mem[int'(wb_addr_o)] : 32'h0;
                if (int'(wb_addr_o) == corrupt_addr) wb_dat_i = wb_dat_i ^ 32'h0000_0100;
            end
        end
    end

    // Reference model: expected beat list for one pass, split into bursts of min(L, remaining).
    int exp_addr[$];
    logic [31:0] exp_dat[$];
    logic [2:0] exp_cti[$];
    function automatic int build_model(input logic [AW-1:0] b, input int n, input int bl, input logic [31:0] s);
        int bursts, i, l, eff;
        logic [15:0] w;
        exp_addr.delete(); exp_dat.delete(); exp_cti.delete();
        bursts = 0; i = 0;
        eff = (bl == 0) ? 1 : bl;
        while (i < n) begin
            l = (n - i < eff) ? n - i : eff;
            for (int k = 0; k < l; k++) begin
                w = 16'(i + k);
                exp_addr.push_back(((int'(b) & ~3) + 4 * (i + k)) & ((1 << AW) - 1));
                exp_dat.push_back(s ^ {w, ~w});
                exp_cti.push_back((k == l - 1) ? 3'b111 : 3'b010);
            end
            i += l;
            bursts++;
        end
        return bursts;
    endfunction

    task automatic clear_log();
        log_we.delete(); log_addr.delete(); log_dat.delete(); log_cti.delete(); gaps.delete();
        gap_run = 0; prev_cyc = 1'b0; stb_cycles = 0; wr_acks = 0; corrupt_addr = -1; stall_beat = -1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n, input int bl, input logic [31:0] s);
        @(negedge clk);
        cfg_base_addr = b; cfg_num_words = 16'(n); cfg_burst_len = 8'(bl); cfg_seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0) begin
            fails++; $display("FAIL reset_status got=%b want=0000", {busy, done, pass, timeout});
        end
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o} !== 10'b0) begin
            fails++; $display("FAIL reset_bus_ctl got=%b want=0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o});
        end
        checks++;
        if (wb_addr_o !== '0 || wb_dat_o !== '0) begin
            fails++; $display("FAIL reset_bus_data addr=%h dat=%h want=0", wb_addr_o, wb_dat_o);
        end
        checks++;
        if (err_count !== '0 || first_err_addr !== '0) begin
            fails++; $display("FAIL reset_err err=%h first=%h want=0", err_count, first_err_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed(input int corrupt);
        int nb, cnt;
        clear_log();
        corrupt_addr = corrupt;
        nb = build_model(26'h100, 16, 4, 32'hA5A5A5A5);
        do_start(26'h100, 16, 4, 32'hA5A5A5A5);
        checks++;
        if (busy !== 1'b1 || wb_stb_o !== 1'b0) begin
            fails++; $display("FAIL dir_start_n1 busy=%b stb=%b want busy=1 stb=0", busy, wb_stb_o);
        end
        @(negedge clk);
        checks++;
        if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) begin
            fails++; $display("FAIL dir_first_stb stb=%b sel=%h want stb=1 sel=f", wb_stb_o, wb_sel_o);
        end
        wait_done(2000, cnt);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL dir_done done=%b busy=%b want done=1 busy=0", done, busy);
        end
        checks++;
        if (pass !== (corrupt < 0) || err_count !== 16'(corrupt >= 0)) begin
            fails++; $display("FAIL dir_result pass=%b err=%0d want pass=%b err=%0d", pass, err_count, corrupt < 0, corrupt >= 0);
        end
        if (corrupt >= 0) begin
            checks++;
            if (int'(first_err_addr) != corrupt) begin
                fails++; $display("FAIL dir_first_err got=%h want=%h", first_err_addr, corrupt);
            end
        end
        checks++;
        if (log_dat.size() == 0 || log_dat[0] !== 32'hA5A55A5A) begin
            fails++; $display("FAIL dir_first_data got=%h want=a5a55a5a", log_dat.size() ? log_dat[0] : 32'h0);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL dir_done_width got=%b want=0", done);
        end
        checks++;
        if (log_addr.size() != 32 || stb_cycles != 32 || gaps.size() != 2 * nb - 1) begin
            fails++; $display("FAIL dir_counts beats=%0d stb=%0d gaps=%0d want 32 32 %0d", log_addr.size(), stb_cycles, gaps.size(), 2 * nb - 1);
        end
        for (int j = 0; j < log_addr.size() && j < 32; j++) begin
            checks++;
            if (log_we[j] !== (j < 16) || log_addr[j] != exp_addr[j % 16] || log_cti[j] !== exp_cti[j % 16] ||
                (j < 16 && log_dat[j] !== exp_dat[j % 16])) begin
                fails++; $display("FAIL dir_beat%0d we=%b addr=%h dat=%h cti=%b want addr=%h dat=%h cti=%b", j,
                    log_we[j], log_addr[j], log_dat[j], log_cti[j], exp_addr[j % 16], exp_dat[j % 16], exp_cti[j % 16]);
            end
        end
    endtask

    task automatic test_short_burst();
        int cnt;
        logic [2:0] want_cti [5];
        want_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b111};
        clear_log();
        do_start(26'h800, 5, 4, 32'h1234_5678);
        wait_done(500, cnt);
        @(negedge clk);
        checks++;
        if (pass !== 1'b1 || stb_cycles != 10 || gaps.size() != 3) begin
            fails++; $display("FAIL short_summary pass=%b stb=%0d gaps=%0d want 1 10 3", pass, stb_cycles, gaps.size());
        end
        for (int j = 0; j < 5 && j < log_cti.size(); j++) begin
            checks++;
            if (log_cti[j] !== want_cti[j]) begin
                fails++; $display("FAIL short_cti%0d got=%b want=%b", j, log_cti[j], want_cti[j]);
            end
        end
        foreach (gaps[j]) begin
            checks++;
            if (gaps[j] != 1) begin
                fails++; $display("FAIL short_gap%0d got=%0d want=1", j, gaps[j]);
            end
        end
    endtask

    task automatic test_random();
        int n, bl, nb, cnt, exp_err;
        logic [AW-1:0] b;
        logic [31:0] s;
        for (int it = 0; it < 6; it++) begin
            clear_log();
            b = (it == 0) ? 26'h3FFFFF8 : AW'($urandom);
            n = (it == 0) ? 6 : $urandom_range(1, 40);
            bl = $urandom_range(0, 9);
            s = $urandom;
            nb = build_model(b, n, bl, s);
            exp_err = 0;
            if ($urandom_range(0, 1) == 1) begin
                corrupt_addr = exp_addr[$urandom_range(0, n - 1)];
                exp_err = 1;
            end
            do_start(b, n, bl, s);
            cfg_base_addr = AW'($urandom); cfg_num_words = 16'($urandom); cfg_burst_len = 8'($urandom); cfg_seed = $urandom;
            wait_done(5000, cnt);
            checks++;
            if (done !== 1'b1 || pass !== (exp_err == 0) || err_count !== 16'(exp_err) ||
                (exp_err == 1 && int'(first_err_addr) != corrupt_addr)) begin
                fails++; $display("FAIL rnd%0d_result done=%b pass=%b err=%0d first=%h want pass=%b err=%0d first=%h", it,
                    done, pass, err_count, first_err_addr, exp_err == 0, exp_err, corrupt_addr);
            end
            @(negedge clk);
            checks++;
            if (log_addr.size() != 2 * n || stb_cycles != 2 * n || gaps.size() != 2 * nb - 1) begin
                fails++; $display("FAIL rnd%0d_counts beats=%0d stb=%0d gaps=%0d want %0d %0d %0d", it,
                    log_addr.size(), stb_cycles, gaps.size(), 2 * n, 2 * n, 2 * nb - 1);
            end
            for (int j = 0; j < log_addr.size() && j < 2 * n; j++) begin
                checks++;
                if (log_we[j] !== (j < n) || log_addr[j] != exp_addr[j % n] || log_cti[j] !== exp_cti[j % n] ||
                    (j < n && log_dat[j] !== exp_dat[j % n])) begin
                    fails++; $display("FAIL rnd%0d_beat%0d addr=%h dat=%h cti=%b want addr=%h dat=%h cti=%b", it, j,
                        log_addr[j], log_dat[j], log_cti[j], exp_addr[j % n], exp_dat[j % n], exp_cti[j % n]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int run, k, cnt;
        bit seen;
        clear_log();
        stall_beat = 2;
        do_start(26'h2000, 16, 4, $urandom);
        run = 0; k = 0; seen = 1'b0;
        while (k < 3000 && !(seen && !wb_stb_o)) begin
            if (wb_stb_o) begin
                seen = 1'b1;
                run++;
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (run != 2 + TO_CYC || wb_cyc_o !== 1'b0) begin
            fails++; $display("FAIL to_stb_run got=%0d cyc=%b want=%0d cyc=0", run, wb_cyc_o, 2 + TO_CYC);
        end
        wait_done(20, cnt);
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL to_result done=%b timeout=%b pass=%b busy=%b want 1 1 0 0", done, timeout, pass, busy);
        end
        stall_beat = -1;
        @(negedge clk);
    endtask

    task automatic test_init_wait_and_empty();
        int stb_seen, cnt;
        clear_log();
        sdr_init_done = 1'b0;
        do_start(26'h40, 8, 3, $urandom);
        stb_seen = 0;
        repeat (200) begin
            if (wb_stb_o !== 1'b0) stb_seen++;
            @(negedge clk);
        end
        sdr_init_done = 1'b1;
        checks++;
        if (stb_seen != 0 || busy !== 1'b1 || wb_stb_o !== 1'b0) begin
            fails++; $display("FAIL init_hold stb_cycles=%0d busy=%b want 0 1", stb_seen, busy);
        end
        @(negedge clk);
        checks++;
        if (wb_stb_o !== 1'b1) begin
            fails++; $display("FAIL init_release stb=%b want=1", wb_stb_o);
        end
        wait_done(500, cnt);
        checks++;
        if (pass !== 1'b1) begin
            fails++; $display("FAIL init_pass got=%b want=1", pass);
        end
        do_start(26'h40, 0, 3, $urandom);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL empty_n1 done=%b busy=%b want 0 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || wb_cyc_o !== 1'b0) begin
            fails++; $display("FAIL empty_done done=%b busy=%b pass=%b cyc=%b want 1 0 1 0", done, busy, pass, wb_cyc_o);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
            fails++; $display("FAIL start_on_done busy=%b done=%b pass=%b want 0 0 1", busy, done, pass);
        end
    endtask

    task automatic test_reset_mid_burst();
        int k, cnt;
        clear_log();
        do_start(26'h4000, 32, 8, $urandom);
        k = 0;
        while (k < 1000 && !(wb_stb_o === 1'b1 && wb_we_o === 1'b0)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(wb_stb_o === 1'b1 && wb_we_o === 1'b0)) begin
            fails++; $display("FAIL rst_reach_read stb=%b we=%b want 1 0", wb_stb_o, wb_we_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_async cyc=%b stb=%b busy=%b want 0 0 0", wb_cyc_o, wb_stb_o, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        do_start(26'h4000, 12, 5, $urandom);
        wait_done(1000, cnt);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin
            fails++; $display("FAIL rst_rerun done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed(-1);
        test_directed(32'h118);
        test_short_burst();
        test_random();
        test_timeout();
        test_init_wait_and_empty();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_mem_bist.md
# wb_mem_bist

Wishbone initiator that exercises the SDRAM controller from the bus side. On a start pulse it writes a deterministic data pattern over a configurable word range using incrementing Wishbone bursts, then reads the range back, compares every beat and reports pass/fail with an error count. It connects directly to the controller's `wb_*` slave port (32-bit application side) and serves as a self-checking traffic source for bring-up and regression.

## Interface
- APP_AW, 26, Wishbone byte-address width
- APP_DW, 32, Wishbone data width (fixed 32; 4 byte lanes)
- TO_CYC, 1023, ack-timeout limit in cycles per beat
- wb_clk_i  in  1  bus clock; all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; ignored while busy
- cfg_base_addr  in  APP_AW  byte start address; bits [1:0] forced to 0
- cfg_num_words  in  16  number of 32-bit words to test
- cfg_burst_len  in  8  beats per burst; 0 treated as 1
- cfg_seed  in  32  pattern seed
- sdr_init_done  in  1  controller init complete
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result, valid from done until next accepted start
- timeout  out  1  set when a beat exceeded TO_CYC
- err_count  out  16  mismatching read beats, saturates at 16'hFFFF
- first_err_addr  out  APP_AW  address of first mismatch
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle/strobe/write
- wb_addr_o  out  APP_AW  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  always 4'hF while stb
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  32  read data

## Operation
- Config is sampled on the accepted start; later changes are ignored until the next start.
- Word i (0..N-1): address = base + 4*i, modulo 2^APP_AW. Data = cfg_seed ^ {i[15:0], ~i[15:0]}.
- States: IDLE, WAIT_INIT, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FINISH.
- IDLE + start: clear err_count, timeout and first_err_addr, then go to WAIT_INIT. If cfg_num_words == 0, go straight to FINISH with pass = 1.
- WAIT_INIT: stays until sdr_init_done = 1, then goes to WR_BURST.
- Burst length L = min(burst_len, remaining words).
- Each burst holds cyc = stb = 1 for L acked beats. cti = 3'b010 on beats 1..L-1 and 3'b111 on the last beat; L = 1 uses 3'b111.
- Address and data advance to the next word in the cycle after each ack.
- After the last ack of a burst, cyc/stb drop for exactly one cycle (the GAP state), then the next burst starts. When the write pass ends, the read pass starts from word 0.
- Read compare happens on every ack with wb_we_o = 0. On a mismatch, err_count increments (saturating). The first mismatch captures its address into first_err_addr.
- Timeout: a per-beat counter runs while stb = 1 and ack = 0. When it reaches TO_CYC, the block drops cyc/stb, sets timeout, and goes to FINISH with pass = 0.
- FINISH: one cycle with done = 1 and busy = 0 from the next cycle. pass = (err_count == 0) && !timeout. Then return to IDLE.
- Reset (asynchronous, any time, including mid-burst): all outputs go to 0, state goes to IDLE, and the bus is released immediately.

## Timing
- Reset values: busy, done, pass, timeout, cyc, stb, we = 0; cti = 3'b000; sel, addr, dat, err_count, first_err_addr = 0.
- start at edge N → busy = 1 from N+1. The first stb comes at N+2 if sdr_init_done was already 1.
- The Wishbone outputs are registered.
- The master never drops stb inside a burst without an ack, except on timeout or reset.
- An ack arriving while stb = 0 is ignored.
- Done is asserted exactly one cycle. busy falls in the same cycle that done rises.
- A start pulse coincident with done is ignored.
- Address wrap past 2^APP_AW - 4 continues at 0, with no error.

## Test plan
- Directed: base 0x100, N = 16, burst 4, seed 0xA5A5A5A5, ideal slave memory with 1-cycle ack → 4 write bursts with cti 010,010,010,111 at addresses 0x100..0x13C; first write data 0xA5A55A5A; done with pass = 1, err_count = 0.
- Same configuration, slave corrupts the read at 0x118 (word 6) → err_count = 1, first_err_addr = 0x118, pass = 0.
- N = 5, burst 4 → bursts of 4 then 1; the single beat uses cti 111; exactly one GAP cycle between bursts.
- Slave never acks the 3rd write → cyc drops after 1023 stalled cycles; timeout = 1, pass = 0, done pulse.
- sdr_init_done held 0 for 200 cycles after start → no stb asserted until 1 cycle after it rises; N = 0 → done 2 cycles after start with pass = 1.
- wb_rst_i asserted low mid read burst → cyc/stb/busy go low asynchronously; after release, a fresh start runs to pass = 1.
